// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational 4-bit ALU between NUM_REQ requesters.
// Optional per-requester saturating grant counters are enabled by defining ALU_ARB_STATS_EN.
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_op,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [3:0]           rsp_data,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [3:0]           alu_op,
    input  logic [3:0]           alu_result,
    output logic [8*NUM_REQ-1:0] grant_cnt
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] scan_idx;
    logic [ID_W-1:0] grant_idx;
    logic            grant_valid;
    logic            can_issue;

    // Nothing is accepted while reset is high, or while a held result is not being taken.
    assign can_issue = !rst && ((state == IDLE) || rsp_ready);
    assign rsp_valid = (state == RESP);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (scan_idx == ID_W'(NUM_REQ - 1)) ? '0 : scan_idx + 1'b1;
            if (can_issue && !grant_valid && req_valid[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = '0;
        if (grant_valid) begin
            req_ready[grant_idx] = 1'b1;
            alu_a  = req_a[{grant_idx, 2'b00} +: 4];
            alu_b  = req_b[{grant_idx, 2'b00} +: 4];
            alu_op = req_op[{grant_idx, 2'b00} +: 4];
        end
    end

    // rr_ptr starts at the last index so requester 0 wins the first contested grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rsp_id   <= '0;
            rsp_data <= '0;
            rr_ptr   <= ID_W'(NUM_REQ - 1);
        end else if (grant_valid) begin
            state    <= RESP;
            rsp_id   <= grant_idx;
            rsp_data <= alu_result;
            rr_ptr   <= grant_idx;
        end else if ((state == RESP) && rsp_ready) begin
            state <= IDLE;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [7:0] grant_cnt_q [NUM_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                grant_cnt_q[i] <= '0;
            end else if (grant_valid && (grant_idx == ID_W'(i)) && (grant_cnt_q[i] != 8'hFF)) begin
                grant_cnt_q[i] <= grant_cnt_q[i] + 8'd1;
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[8*i +: 8] = grant_cnt_q[i];
        end
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed steps plus random traffic against a
// transaction-level model; honours ALU_ARB_STATS_EN for the grant counter expectations.
module tb_alu_share_arbiter;

    localparam int N    = 2;
    localparam int ID_W = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [4*N-1:0] req_op;
    logic [4*N-1:0] req_a;
    logic [4*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [ID_W-1:0] rsp_id;
    logic [3:0]     rsp_data;
    logic [3:0]     alu_a;
    logic [3:0]     alu_b;
    logic [3:0]     alu_op;
    logic [3:0]     alu_result;
    logic [8*N-1:0] grant_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_last;
    bit m_have;
    int m_id;
    int m_data;
    int m_cnt [N];

    always #5 clk = ~clk;

    // Comparisons report 4'hF for true, 0 for false.
    function automatic logic [3:0] alu_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            4'd0:    return 4'(a + b);
            4'd1:    return 4'(a - b);
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return (a == b) ? 4'hF : 4'h0;
            4'd5:    return ~a;
            4'd6:    return (a > b) ? 4'hF : 4'h0;
            4'd7:    return (a < b) ? 4'hF : 4'h0;
            default: return 4'h0;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_op, alu_a, alu_b);

    alu_share_arbiter #(.NUM_REQ(N), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .grant_cnt(grant_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_last = N - 1;
        m_have = 1'b0;
        m_id   = 0;
        m_data = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // Drive one cycle, check mid-cycle against the model, then advance the model over the edge.
    task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic [4*N-1:0] op,
                                 input logic [4*N-1:0] a, input logic [4*N-1:0] b, input logic rr);
        int             g;
        logic [N-1:0]   exp_ready;
        logic [3:0]     ea, eb, eo;
        logic [8*N-1:0] ecnt;
        rst = r; req_valid = v; req_op = op; req_a = a; req_b = b; rsp_ready = rr;
        @(negedge clk);
        g = -1;
        if (!r && (!m_have || rr)) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (g < 0 && v[i]) g = i;
            end
        end
        exp_ready = '0;
        ea = '0; eb = '0; eo = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            ea = a[4*g +: 4];
            eb = b[4*g +: 4];
            eo = op[4*g +: 4];
        end
        ecnt = '0;
`ifdef ALU_ARB_STATS_EN
        for (int i = 0; i < N; i++) ecnt[8*i +: 8] = 8'(m_cnt[i]);
`endif
        checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
        checkOutput("alu_a", 32'(alu_a), 32'(ea));
        checkOutput("alu_b", 32'(alu_b), 32'(eb));
        checkOutput("alu_op", 32'(alu_op), 32'(eo));
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_have));
        checkOutput("rsp_id", 32'(rsp_id), 32'(m_id));
        checkOutput("rsp_data", 32'(rsp_data), 32'(m_data));
        checkOutput("grant_cnt", 32'(grant_cnt), 32'(ecnt));
        @(posedge clk);
        if (r) begin
            modelReset();
        end else if (g >= 0) begin
            m_have = 1'b1;
            m_id   = g;
            m_data = int'(alu_ref(op[4*g +: 4], a[4*g +: 4], b[4*g +: 4]));
            m_last = g;
            if (m_cnt[g] < 255) m_cnt[g]++;
        end else if (m_have && rr) begin
            m_have = 1'b0;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        modelReset();

        // Held in reset with requests pending: nothing accepted.
        applyStimulus(1'b1, 2'b11, 8'h00, 8'h21, 8'h43, 1'b1);

        // First transaction: 3+4 from requester 0.
        applyStimulus(1'b0, 2'b01, 8'h00, 8'h03, 8'h04, 1'b1);
        checkOutput("first_valid", 32'(rsp_valid), 32'd1);
        checkOutput("first_id", 32'(rsp_id), 32'd0);
        checkOutput("first_data", 32'(rsp_data), 32'd7);
        applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b1);

        // Alternating grants after reset.
        applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 2'b11, 8'h00, 8'h21, 8'h21, 1'b1);
            checkOutput("alt_id", 32'(rsp_id), 32'(k % 2));
            checkOutput("alt_data", 32'(rsp_data), (k % 2 == 0) ? 32'd2 : 32'd4);
        end

        // Backpressure with a held 0xF result.
        applyStimulus(1'b0, 2'b01, 8'h06, 8'h09, 8'h02, 1'b1);
        checkOutput("gt_data", 32'(rsp_data), 32'hF);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 2'b11, 8'h10, 8'h59, 8'h32, 1'b0);
            checkOutput("stall_data", 32'(rsp_data), 32'hF);
            checkOutput("stall_id", 32'(rsp_id), 32'd0);
        end
        applyStimulus(1'b0, 2'b11, 8'h10, 8'h59, 8'h32, 1'b1);
        checkOutput("release_id", 32'(rsp_id), 32'd1);
        checkOutput("release_data", 32'(rsp_data), 32'd2);

        // 4-bit modulo arithmetic and unused opcodes.
        applyStimulus(1'b0, 2'b10, 8'h10, 8'h30, 8'h50, 1'b1);
        checkOutput("sub_wrap", 32'(rsp_data), 32'd14);
        applyStimulus(1'b0, 2'b10, 8'h90, 8'h70, 8'h30, 1'b1);
        checkOutput("op9_zero", 32'(rsp_data), 32'd0);
        applyStimulus(1'b0, 2'b10, 8'h50, 8'h00, 8'h00, 1'b1);
        checkOutput("not_zero", 32'(rsp_data), 32'd15);
        applyStimulus(1'b0, 2'b10, 8'h00, 8'h90, 8'h90, 1'b1);
        checkOutput("add_wrap", 32'(rsp_data), 32'd2);

        // Reset pulse while a result is held.
        applyStimulus(1'b0, 2'b01, 8'h00, 8'h01, 8'h01, 1'b0);
        applyStimulus(1'b1, 2'b11, 8'h00, 8'h11, 8'h11, 1'b0);
        checkOutput("rst_drop_valid", 32'(rsp_valid), 32'd0);
        applyStimulus(1'b0, 2'b11, 8'h00, 8'h12, 8'h12, 1'b1);
        checkOutput("rst_rr_restart", 32'(rsp_id), 32'd0);
        checkOutput("rst_rr_data", 32'(rsp_data), 32'd4);

        // Random traffic with occasional reset.
        for (int k = 0; k < 250; k++) begin
            applyStimulus(($urandom_range(0, 39) == 0), 2'($urandom), 8'($urandom),
                          8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Counter saturation on requester 1.
        applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 1'b1);
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1'b0, 2'b10, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        end
`ifdef ALU_ARB_STATS_EN
        checkOutput("cnt1_sat", 32'(grant_cnt[15:8]), 32'd255);
`else
        checkOutput("cnt1_off", 32'(grant_cnt[15:8]), 32'd0);
`endif
        checkOutput("cnt0_idle", 32'(grant_cnt[7:0]), 32'd0);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
